// File: rtl/regport_arbiter.sv
// rtl/regport_arbiter.sv - round-robin arbiter for the register file auxiliary read port
module regport_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    hold,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [AW-1:0]      rf_addr,
  input  logic [DW-1:0]      rf_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [AW-1:0] a_reg_q, a_reg_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [IW:0]   arb_idle, arb_resp;

  // First requester set at or after p+1, wrapping; MSB flags a winner.
  function automatic logic [IW:0] arb(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW:0] res;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (r[(int'(p) + k) % NREQ]) res = {1'b1, IW'((int'(p) + k) % NREQ)};
    end
    return res;
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [NREQ*AW-1:0] a, input logic [IW-1:0] i);
    return a[int'(i)*AW +: AW];
  endfunction

  // Next-state: arbitration from IDLE, data capture in GRANT, chain or re-arbitrate in RESP.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    hcnt_d   = hcnt_q;
    a_reg_d  = a_reg_q;
    rdata_d  = rdata_q;
    arb_idle = arb(req, ptr_q);
    arb_resp = arb(req, owner_q);
    case (state_q)
      S_IDLE: begin
        if (arb_idle[IW]) begin
          owner_d = arb_idle[IW-1:0];
          a_reg_d = addr_of(addr, arb_idle[IW-1:0]);
          hcnt_d  = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        rdata_d = rf_data;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (hold[owner_q] && req[owner_q] && (hcnt_q < HW'(MAX_HOLD - 1))) begin
          hcnt_d  = hcnt_q + HW'(1);
          a_reg_d = addr_of(addr, owner_q);
          state_d = S_GRANT;
        end else begin
          // Search starts after the departing owner, so it becomes lowest priority.
          ptr_d = owner_q;
          if (arb_resp[IW]) begin
            owner_d = arb_resp[IW-1:0];
            a_reg_d = addr_of(addr, arb_resp[IW-1:0]);
            hcnt_d  = '0;
            state_d = S_GRANT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state and owner only.
  always_comb begin
    gnt     = '0;
    rvalid  = '0;
    rf_addr = '0;
    if (state_q == S_GRANT) begin
      gnt[owner_q] = 1'b1;
      rf_addr      = a_reg_q;
    end
    if (state_q == S_RESP) rvalid[owner_q] = 1'b1;
  end

  assign rdata = rdata_q;

  // State registers with synchronous active-low reset; pointer starts so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(NREQ - 1);
      hcnt_q  <= '0;
      a_reg_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      a_reg_q <= a_reg_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_regport_arbiter.sv
// tb/tb_regport_arbiter.sv - directed self-checking bench for regport_arbiter
module tb_regport_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, hold;
  logic [19:0] addr;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] rf_mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  regport_arbiter #(.NREQ(4), .AW(5), .DW(32), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .hold(hold), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  always #5 clk = ~clk;

  // Combinational register-file model.
  always_comb rf_data = rf_mem[rf_addr];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req = '0; hold = '0; addr = '0;
    tick();
    tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0000", rvalid); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    addr[1*5 +: 5] = 5'd9;
    req = 4'b0010;
    tick();
    n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL single_gnt: got %b want 0010", gnt); end
    n_checks++; if (rf_addr !== 5'd9) begin n_fail++; $display("FAIL single_rf_addr: got %0d want 9", rf_addr); end
    n_checks++; if (rvalid !== 4'b0000) begin n_fail++; $display("FAIL single_rvalid_early: got %b want 0000", rvalid); end
    tick();
    n_checks++; if (rvalid !== 4'b0010) begin n_fail++; $display("FAIL single_rvalid: got %b want 0010", rvalid); end
    n_checks++; if (rdata !== 32'h5) begin n_fail++; $display("FAIL single_rdata: got %h want 5", rdata); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_resp: got %b want 0000", gnt); end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if ({gnt, rvalid, rf_addr} !== 13'd0) begin n_fail++; $display("FAIL single_idle%0d: got gnt=%b rvalid=%b rf_addr=%0d want all 0", c, gnt, rvalid, rf_addr); end
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp;
    apply_reset();
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(12 + i);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      tick();
      n_checks++; if (gnt !== exp) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b", g, gnt, exp); end
      n_checks++; if (rf_addr !== 5'(12 + g % 4)) begin n_fail++; $display("FAIL rr_rf_addr%0d: got %0d want %0d", g, rf_addr, 12 + g % 4); end
      tick();
      n_checks++; if (rvalid !== exp || gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_rvalid%0d: got rvalid=%b gnt=%b want rvalid=%b gnt=0000", g, rvalid, gnt, exp); end
      n_checks++; if (rdata !== 32'hC0DE_0000 + 32'(12 + g % 4)) begin n_fail++; $display("FAIL rr_rdata%0d: got %h want %h", g, rdata, 32'hC0DE_0000 + 32'(12 + g % 4)); end
      if (g == 4) req = 4'b0000;
    end
    tick();
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_idle: got %b want 0000", gnt); end
  endtask

  task automatic test_hold_burst();
    apply_reset();
    addr[0 +: 5] = 5'd8;
    addr[2*5 +: 5] = 5'd20;
    req = 4'b0101; hold = 4'b0001;
    for (int r = 0; r < 4; r++) begin
      tick();
      n_checks++; if (gnt !== 4'b0001 || rf_addr !== 5'(8 + r)) begin n_fail++; $display("FAIL hold_gnt%0d: got gnt=%b rf_addr=%0d want 0001/%0d", r, gnt, rf_addr, 8 + r); end
      tick();
      n_checks++; if (rvalid !== 4'b0001 || rdata !== 32'hC0DE_0000 + 32'(8 + r)) begin n_fail++; $display("FAIL hold_rvalid%0d: got rvalid=%b rdata=%h want 0001/%h", r, rvalid, rdata, 32'hC0DE_0000 + 32'(8 + r)); end
      addr[0 +: 5] = 5'(9 + r);
    end
    hold = 4'b0000; req = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100 || rf_addr !== 5'd20) begin n_fail++; $display("FAIL hold_next_gnt: got gnt=%b rf_addr=%0d want 0100/20", gnt, rf_addr); end
    tick();
    n_checks++; if (rvalid !== 4'b0100 || rdata !== 32'hC0DE_0014) begin n_fail++; $display("FAIL hold_next_rvalid: got rvalid=%b rdata=%h want 0100/c0de0014", rvalid, rdata); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_max_hold();
    int served;
    apply_reset();
    addr[0 +: 5] = 5'd4;
    addr[3*5 +: 5] = 5'd7;
    req = 4'b1001; hold = 4'b0001;
    served = 0;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (gnt === 4'b0001) begin
        tick();
        if (rvalid === 4'b0001) served++;
      end else begin
        tick();
      end
    end
    n_checks++; if (served !== 8) begin n_fail++; $display("FAIL maxhold_count: got %0d owner-0 reads want 8", served); end
    tick();
    n_checks++; if (gnt !== 4'b1000 || rf_addr !== 5'd7) begin n_fail++; $display("FAIL maxhold_release: got gnt=%b rf_addr=%0d want 1000/7", gnt, rf_addr); end
    tick();
    n_checks++; if (rvalid !== 4'b1000 || rdata !== 32'hC0DE_0007) begin n_fail++; $display("FAIL maxhold_rvalid3: got rvalid=%b rdata=%h want 1000/c0de0007", rvalid, rdata); end
    req = 4'b0000; hold = 4'b0000;
    tick();
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(1 + i);
    req = 4'b1111;
    tick();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL midop_pre_gnt: got %b want 0001", gnt); end
    rst = 1'b0;
    tick();
    n_checks++; if ({gnt, rvalid, rf_addr} !== 13'd0 || rdata !== 32'h0) begin n_fail++; $display("FAIL midop_reset: got gnt=%b rvalid=%b rf_addr=%0d rdata=%h want all 0", gnt, rvalid, rf_addr, rdata); end
    tick();
    n_checks++; if (rvalid !== 4'b0000 || gnt !== 4'b0000) begin n_fail++; $display("FAIL midop_no_rvalid: got rvalid=%b gnt=%b want 0000/0000", rvalid, gnt); end
    rst = 1'b1;
    tick();
    n_checks++; if (gnt !== 4'b0001 || rf_addr !== 5'd1) begin n_fail++; $display("FAIL midop_after_gnt: got gnt=%b rf_addr=%0d want 0001/1", gnt, rf_addr); end
    req = 4'b0000;
    tick();
    n_checks++; if (rvalid !== 4'b0001 || rdata !== 32'hC0DE_0001) begin n_fail++; $display("FAIL midop_after_rvalid: got rvalid=%b rdata=%h want 0001/c0de0001", rvalid, rdata); end
    tick();
  endtask

  task automatic test_withdrawal();
    addr[2*5 +: 5] = 5'd21;
    req = 4'b0100;
    tick();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL wd_gnt: got %b want 0100", gnt); end
    req = 4'b0000;
    addr[2*5 +: 5] = 5'd3;
    tick();
    n_checks++; if (rvalid !== 4'b0100 || rdata !== 32'hC0DE_0015) begin n_fail++; $display("FAIL wd_rvalid: got rvalid=%b rdata=%h want 0100/c0de0015", rvalid, rdata); end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++; if ({gnt, rvalid} !== 8'd0 || rdata !== 32'hC0DE_0015) begin n_fail++; $display("FAIL wd_idle%0d: got gnt=%b rvalid=%b rdata=%h want 0/0/c0de0015", c, gnt, rvalid, rdata); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hC0DE_0000 + 32'(i);
    rf_mem[9] = 32'h5;
    test_reset();
    test_single();
    rf_mem[9] = 32'hC0DE_0009;
    test_contention();
    test_hold_burst();
    test_max_hold();
    test_reset_midop();
    test_withdrawal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
